usb_rx_ctrl: RTL and testbench

//  Receive control unit for the USB full-speed RX path. Sequences the decode,

---
 rtl/usb_rx_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_ctrl
//   Receive control unit for the USB full-speed RX path. Steps the RX datapath
//   through one packet: sync byte check, PID check, payload byte writes into
//   the RX FIFO, EOP handling and sticky error reporting.
//
// Ports
//   clk            in   1      system clock, rising edge
//   rst            in   1      synchronous reset, active-high
//   d_edge         in   1      transition seen on d_plus
//   eop            in   1      SE0 seen by the decoder
//   shift_enable   in   1      bit-sample strobe from the bit timer
//   byte_received  in   1      1-cycle pulse, rcv_data holds a full byte
//   rcv_data       in   8      parallel byte from the RX shift register
//   fifo_full      in   1      RX FIFO cannot take a write
//   rcving         out  1      packet in progress (enables the bit timer)
//   w_enable       out  1      1-cycle FIFO write strobe for rcv_data
//   r_error        out  1      sticky receive error flag
//   rx_pid         out  4      PID of the current/last good packet
//   pid_valid      out  1      rx_pid was checked good for this packet
//   byte_count     out  CNT_W  payload bytes written this packet
//   pkt_done       out  1      1-cycle pulse, packet ended cleanly
//
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module usb_rx_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'h80,
   parameter int         MAX_BYTES = 64,
   parameter int         CNT_W     = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_edge,
   input  logic             eop,
   input  logic             shift_enable,
   input  logic             byte_received,
   input  logic [7:0]       rcv_data,
   input  logic             fifo_full,
   output logic             rcving,
   output logic             w_enable,
   output logic             r_error,
   output logic [3:0]       rx_pid,
   output logic             pid_valid,
   output logic [CNT_W-1:0] byte_count,
   output logic             pkt_done
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SYNC_WAIT = 4'd1,
      SYNC_CHK  = 4'd2,
      PID_WAIT  = 4'd3,
      PID_CHK   = 4'd4,
      DATA_WAIT = 4'd5,
      STORE     = 4'd6,
      EOP_WAIT  = 4'd7,
      ERR       = 4'd8,
      ERR_IDLE  = 4'd9
   } state_t;

   // A PID byte is valid when its upper nibble is the complement of the lower.
   function automatic logic pid_check(input logic [7:0] pid_byte);
      return (pid_byte[7:4] == ~pid_byte[3:0]);
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             eop_se_s;
   logic             store_ok_s;
   logic             pid_take_s;
   logic             enter_sync_s;
   logic             rcving_next_s;

   logic             rcving_r;
   logic             w_enable_r;
   logic             r_error_r;
   logic [3:0]       rx_pid_r;
   logic             pid_valid_r;
   logic [CNT_W-1:0] byte_count_r;
   logic             pkt_done_r;

   assign eop_se_s = eop & shift_enable;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode plus the one-cycle qualifiers that feed the output flops.
   // The write decision (FIFO space, byte limit) is taken in the same cycle as
   // byte_received so the strobe can be registered and still land in STORE.
   always_comb begin
      next_state_s = state_r;
      store_ok_s   = 1'b0;
      pid_take_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (d_edge) next_state_s = SYNC_WAIT;
            else        next_state_s = IDLE;
         end
         SYNC_WAIT: begin
            if (eop_se_s)           next_state_s = ERR;
            else if (byte_received) next_state_s = SYNC_CHK;
            else                    next_state_s = SYNC_WAIT;
         end
         SYNC_CHK: begin
            if (rcv_data == SYNC_BYTE) next_state_s = PID_WAIT;
            else                       next_state_s = ERR;
         end
         PID_WAIT: begin
            if (eop_se_s)           next_state_s = ERR;
            else if (byte_received) next_state_s = PID_CHK;
            else                    next_state_s = PID_WAIT;
         end
         PID_CHK: begin
            if (pid_check(rcv_data)) begin
               next_state_s = DATA_WAIT;
               pid_take_s   = 1'b1;
            end else begin
               next_state_s = ERR;
            end
         end
         DATA_WAIT: begin
            // eop takes priority; a byte completing alongside it is dropped
            if (eop_se_s) begin
               next_state_s = EOP_WAIT;
            end else if (byte_received) begin
               next_state_s = STORE;
               store_ok_s   = ~fifo_full && (byte_count_r != CNT_W'(MAX_BYTES));
            end else begin
               next_state_s = DATA_WAIT;
            end
         end
         STORE: begin
            // w_enable_r is high exactly when the write was accepted
            if (w_enable_r) next_state_s = DATA_WAIT;
            else            next_state_s = ERR;
         end
         EOP_WAIT: begin
            if (d_edge) next_state_s = IDLE;
            else        next_state_s = EOP_WAIT;
         end
         ERR: begin
            if (eop_se_s) next_state_s = ERR_IDLE;
            else          next_state_s = ERR;
         end
         ERR_IDLE: begin
            if (d_edge) next_state_s = IDLE;
            else        next_state_s = ERR_IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // rcving decode of the state being entered, so the flop tracks the state.
   always_comb begin
      rcving_next_s = 1'b0;
      case (next_state_s)
         SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK,
         DATA_WAIT, STORE, ERR:       rcving_next_s = 1'b1;
         IDLE, EOP_WAIT, ERR_IDLE:    rcving_next_s = 1'b0;
         default:                     rcving_next_s = 1'b0;
      endcase
   end

   assign enter_sync_s = (state_r == IDLE) && (next_state_s == SYNC_WAIT);

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rcving_r     <= 1'b0;
         w_enable_r   <= 1'b0;
         r_error_r    <= 1'b0;
         rx_pid_r     <= 4'h0;
         pid_valid_r  <= 1'b0;
         byte_count_r <= '0;
         pkt_done_r   <= 1'b0;
      end else begin
         rcving_r   <= rcving_next_s;
         w_enable_r <= store_ok_s;
         pkt_done_r <= (state_r == EOP_WAIT) && (next_state_s == IDLE);
         if (enter_sync_s) begin
            // new packet: error, PID flag and count start fresh; rx_pid is kept
            r_error_r    <= 1'b0;
            pid_valid_r  <= 1'b0;
            byte_count_r <= '0;
         end else begin
            if (next_state_s == ERR) begin
               r_error_r <= 1'b1;
            end
            if (pid_take_s) begin
               rx_pid_r    <= rcv_data[3:0];
               pid_valid_r <= 1'b1;
            end
            // store_ok_s already excludes byte_count == MAX_BYTES: saturates
            if (store_ok_s) begin
               byte_count_r <= byte_count_r + CNT_W'(1);
            end
         end
      end
   end

   assign rcving     = rcving_r;
   assign w_enable   = w_enable_r;
   assign r_error    = r_error_r;
   assign rx_pid     = rx_pid_r;
   assign pid_valid  = pid_valid_r;
   assign byte_count = byte_count_r;
   assign pkt_done   = pkt_done_r;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_ctrl
//   Directed bench for usb_rx_ctrl. Inputs change 1 ns after a rising edge and
//   outputs are sampled at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_usb_rx_ctrl;

   logic       tb_clk = 1'b0;
   logic       rst;
   logic       d_edge;
   logic       eop;
   logic       shift_enable;
   logic       byte_received;
   logic [7:0] rcv_data;
   logic       fifo_full;
   logic       rcving;
   logic       w_enable;
   logic       r_error;
   logic [3:0] rx_pid;
   logic       pid_valid;
   logic [6:0] byte_count;
   logic       pkt_done;

   int checks = 0;
   int errors = 0;
   int wr_total = 0;
   int done_total = 0;
   int wr_base;
   int done_base;

   usb_rx_ctrl dut (
      .clk           (tb_clk),
      .rst           (rst),
      .d_edge        (d_edge),
      .eop           (eop),
      .shift_enable  (shift_enable),
      .byte_received (byte_received),
      .rcv_data      (rcv_data),
      .fifo_full     (fifo_full),
      .rcving        (rcving),
      .w_enable      (w_enable),
      .r_error       (r_error),
      .rx_pid        (rx_pid),
      .pid_valid     (pid_valid),
      .byte_count    (byte_count),
      .pkt_done      (pkt_done)
   );

   always #5 tb_clk = ~tb_clk;

   // count strobe cycles between edges
   always @(negedge tb_clk) begin
      if (w_enable === 1'b1) wr_total++;
      if (pkt_done === 1'b1) done_total++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic pulse_edge();
      d_edge = 1'b1;
      cyc();
      d_edge = 1'b0;
   endtask

   task automatic eop_seq();
      eop = 1'b1;
      shift_enable = 1'b1;
      cyc();
      eop = 1'b0;
      shift_enable = 1'b0;
   endtask

   // sync/PID byte: one cycle of byte_received, one cycle in the check state
   task automatic hdr_byte(input logic [7:0] b);
      rcv_data = b;
      byte_received = 1'b1;
      cyc();
      byte_received = 1'b0;
      cyc();
   endtask

   // payload byte: w_enable must follow byte_received by exactly one cycle
   task automatic data_byte(input logic [7:0] b, input logic exp_we);
      rcv_data = b;
      byte_received = 1'b1;
      cyc();
      byte_received = 1'b0;
      chk("w_enable_n_plus_1", w_enable, exp_we);
      cyc();
   endtask

   initial begin
      rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
      byte_received = 1'b0; rcv_data = 8'h00; fifo_full = 1'b0;
      cyc(); cyc();
      chk("rst_rcving", rcving, 1'b0);
      chk("rst_w_enable", w_enable, 1'b0);
      chk("rst_r_error", r_error, 1'b0);
      chk("rst_rx_pid", rx_pid, 4'h0);
      chk("rst_pid_valid", pid_valid, 1'b0);
      chk("rst_byte_count", byte_count, 7'd0);
      chk("rst_pkt_done", pkt_done, 1'b0);
      rst = 1'b0;
      cyc();

      // good packet: sync, ACK PID, A5/3C/FF, EOP, return edge
      wr_base = wr_total; done_base = done_total;
      pulse_edge();
      chk("good_rcving_rise", rcving, 1'b1);
      hdr_byte(8'h80);
      hdr_byte(8'hD2);
      chk("good_rx_pid", rx_pid, 4'h2);
      chk("good_pid_valid", pid_valid, 1'b1);
      pulse_edge();
      chk("d_edge_ignored_data", rcving, 1'b1);
      data_byte(8'hA5, 1'b1);
      data_byte(8'h3C, 1'b1);
      data_byte(8'hFF, 1'b1);
      chk("good_byte_count", byte_count, 7'd3);
      eop_seq();
      chk("good_eop_rcving", rcving, 1'b0);
      chk("good_no_done_yet", pkt_done, 1'b0);
      pulse_edge();
      chk("good_pkt_done", pkt_done, 1'b1);
      chk("good_r_error", r_error, 1'b0);
      cyc();
      chk("good_pkt_done_1cyc", pkt_done, 1'b0);
      chk("good_writes", wr_total - wr_base, 3);
      chk("good_done_count", done_total - done_base, 1);

      // reset mid-packet, asserted while a write strobe is high
      pulse_edge();
      hdr_byte(8'h80);
      hdr_byte(8'hD2);
      rcv_data = 8'h5A;
      byte_received = 1'b1;
      cyc();
      byte_received = 1'b0;
      chk("midrst_we_before", w_enable, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_rcving", rcving, 1'b0);
      chk("midrst_w_enable", w_enable, 1'b0);
      chk("midrst_r_error", r_error, 1'b0);
      chk("midrst_byte_count", byte_count, 7'd0);
      chk("midrst_rx_pid", rx_pid, 4'h0);
      cyc();
      chk("midrst_idle_rcving", rcving, 1'b0);

      // bad sync byte
      wr_base = wr_total;
      pulse_edge();
      hdr_byte(8'h81);
      chk("badsync_r_error", r_error, 1'b1);
      chk("badsync_rcving", rcving, 1'b1);
      eop_seq();
      chk("badsync_eop_rcving", rcving, 1'b0);
      chk("badsync_sticky", r_error, 1'b1);
      pulse_edge();
      chk("badsync_no_write", wr_total - wr_base, 0);
      // next good packet clears r_error on its start
      pulse_edge();
      chk("restart_r_error", r_error, 1'b0);
      hdr_byte(8'h80);
      hdr_byte(8'h69);
      chk("data1_rx_pid", rx_pid, 4'h9);
      eop_seq();
      pulse_edge();
      chk("data1_pkt_done", pkt_done, 1'b1);

      // bad PID
      pulse_edge();
      hdr_byte(8'h80);
      hdr_byte(8'hD3);
      chk("badpid_r_error", r_error, 1'b1);
      chk("badpid_pid_valid", pid_valid, 1'b0);
      chk("badpid_byte_count", byte_count, 7'd0);
      chk("badpid_rx_pid_kept", rx_pid, 4'h9);
      eop_seq();
      pulse_edge();

      // overflow: 65 payload bytes
      wr_base = wr_total;
      pulse_edge();
      hdr_byte(8'h80);
      hdr_byte(8'hD2);
      for (int i = 0; i < 64; i++) begin
         data_byte(8'(i), 1'b1);
      end
      chk("ovf_count_max", byte_count, 7'd64);
      chk("ovf_no_err_yet", r_error, 1'b0);
      data_byte(8'hEE, 1'b0);
      chk("ovf_r_error", r_error, 1'b1);
      chk("ovf_count_sat", byte_count, 7'd64);
      chk("ovf_writes", wr_total - wr_base, 64);
      eop_seq();
      pulse_edge();

      // FIFO full on the second byte
      wr_base = wr_total;
      pulse_edge();
      chk("full_count_cleared", byte_count, 7'd0);
      hdr_byte(8'h80);
      hdr_byte(8'hD2);
      data_byte(8'h11, 1'b1);
      fifo_full = 1'b1;
      data_byte(8'h22, 1'b0);
      fifo_full = 1'b0;
      chk("full_r_error", r_error, 1'b1);
      chk("full_byte_count", byte_count, 7'd1);
      chk("full_writes", wr_total - wr_base, 1);
      eop_seq();
      pulse_edge();

      // early EOP in PID_WAIT
      done_base = done_total;
      pulse_edge();
      hdr_byte(8'h80);
      eop_seq();
      chk("early_r_error", r_error, 1'b1);
      chk("early_rcving_err", rcving, 1'b1);
      eop_seq();
      chk("early_rcving_erridle", rcving, 1'b0);
      pulse_edge();
      chk("early_pkt_done_now", pkt_done, 1'b0);
      cyc();
      chk("early_no_pkt_done", done_total - done_base, 0);

      // eop and byte_received together in DATA_WAIT
      wr_base = wr_total;
      pulse_edge();
      hdr_byte(8'h80);
      hdr_byte(8'hD2);
      rcv_data = 8'h77;
      byte_received = 1'b1;
      eop = 1'b1;
      shift_enable = 1'b1;
      cyc();
      byte_received = 1'b0;
      eop = 1'b0;
      shift_enable = 1'b0;
      chk("simul_w_enable", w_enable, 1'b0);
      chk("simul_rcving", rcving, 1'b0);
      cyc();
      pulse_edge();
      chk("simul_pkt_done", pkt_done, 1'b1);
      chk("simul_r_error", r_error, 1'b0);
      chk("simul_byte_count", byte_count, 7'd0);
      cyc();
      chk("simul_no_write", wr_total - wr_base, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
